// File: rtl/imm_gen_stream_if.sv
// Streaming handshake bundle for the immediate generator: instruction in, decoded immediate out.
interface imm_gen_stream_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_count;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, illegal_count
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, illegal_count
    );
endinterface

// File: rtl/imm_gen_stream.sv
// RISC-V immediate generator with a 2-entry output FIFO and a saturating illegal-opcode counter.
module imm_gen_stream #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    imm_gen_stream_if.slave   bus
);
    localparam logic [2:0] FmtI    = 3'd0;
    localparam logic [2:0] FmtS    = 3'd1;
    localparam logic [2:0] FmtB    = 3'd2;
    localparam logic [2:0] FmtU    = 3'd3;
    localparam logic [2:0] FmtJ    = 3'd4;
    localparam logic [2:0] FmtNone = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    localparam entry_t EntryIdle = '{imm: '0, fmt: FmtNone, illegal: 1'b0};

    state_e           state_q, state_d;
    entry_t           head_q, head_d, tail_q, tail_d;
    entry_t           dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      instr;
    logic [31:0]      raw;
    logic             push, pop;

    assign instr = bus.in_instr;

    // Every field is first sign-extended to 32 bits, then widened by a signed cast.
    always_comb begin
        raw         = '0;
        dec.fmt     = FmtNone;
        dec.illegal = 1'b1;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                raw     = {{20{instr[31]}}, instr[31:20]};
                dec.fmt = FmtI;
            end
            7'b0100011: begin
                raw     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec.fmt = FmtS;
            end
            7'b1100011: begin
                raw     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                dec.fmt = FmtB;
            end
            7'b0110111, 7'b0010111: begin
                raw     = {instr[31:12], 12'b0};
                dec.fmt = FmtU;
            end
            7'b1101111: begin
                raw     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                dec.fmt = FmtJ;
            end
            default: ;
        endcase
        dec.illegal = (dec.fmt == FmtNone);
        dec.imm     = XLEN'($signed(raw));
    end

    // Reset gates in_ready directly so nothing is accepted while reset is high.
    assign bus.in_ready  = !reset && (state_q != StFull);
    assign bus.out_valid = (state_q != StEmpty);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = dec;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    head_d = dec;
                end else if (push) begin
                    tail_d  = dec;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (push && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            head_q  <= EntryIdle;
            tail_q  <= EntryIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stale head contents are masked once the buffer drains.
    assign bus.out_imm       = bus.out_valid ? head_q.imm : '0;
    assign bus.out_fmt       = bus.out_valid ? head_q.fmt : FmtNone;
    assign bus.out_illegal   = bus.out_valid ? head_q.illegal : 1'b0;
    assign bus.illegal_count = cnt_q;
endmodule

// File: tb/tb_imm_gen_stream.sv
// Directed bench: an XLEN=64/CNT_W=2 and an XLEN=32/CNT_W=16 instance driven in lockstep.
module tb_imm_gen_stream;
    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;
    int   exp64;
    int   exp32;

    imm_gen_stream_if #(.XLEN(64), .CNT_W(2))  b64 ();
    imm_gen_stream_if #(.XLEN(32), .CNT_W(16)) b32 ();

    imm_gen_stream #(.XLEN(64), .CNT_W(2))  u64 (.clk(clk), .reset(reset), .bus(b64.slave));
    imm_gen_stream #(.XLEN(32), .CNT_W(16)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy);
        b64.in_valid  = v;
        b64.in_instr  = ins;
        b64.out_ready = rdy;
        b32.in_valid  = v;
        b32.in_instr  = ins;
        b32.out_ready = rdy;
    endtask

    task automatic check_head(input string name, input logic [63:0] imm, input logic [2:0] fmt,
                              input logic ill);
        check({name, " valid64"}, 64'(b64.out_valid), 64'(1'b1));
        check({name, " imm64"}, b64.out_imm, imm);
        check({name, " fmt64"}, 64'(b64.out_fmt), 64'(fmt));
        check({name, " ill64"}, 64'(b64.out_illegal), 64'(ill));
        check({name, " valid32"}, 64'(b32.out_valid), 64'(1'b1));
        check({name, " imm32"}, 64'(b32.out_imm), {32'b0, imm[31:0]});
        check({name, " fmt32"}, 64'(b32.out_fmt), 64'(fmt));
    endtask

    task automatic check_cnt(input string name);
        check({name, " cnt64"}, 64'(b64.illegal_count), 64'(exp64));
        check({name, " cnt32"}, 64'(b32.illegal_count), 64'(exp32));
    endtask

    task automatic check_idle(input string name);
        check({name, " valid64"}, 64'(b64.out_valid), 64'(1'b0));
        check({name, " imm64"}, b64.out_imm, 64'd0);
        check({name, " fmt64"}, 64'(b64.out_fmt), 64'd7);
        check({name, " ill64"}, 64'(b64.out_illegal), 64'd0);
        check({name, " valid32"}, 64'(b32.out_valid), 64'(1'b0));
        check({name, " rdy64"}, 64'(b64.in_ready), 64'(1'b1));
        check({name, " rdy32"}, 64'(b32.in_ready), 64'(1'b1));
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        exp64  = 0;
        exp32  = 0;
        vecs[0]  = '{"addi -1",   32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0};
        vecs[1]  = '{"beq -4",    32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
        vecs[2]  = '{"sw -8",     32'hFE20AC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0};
        vecs[3]  = '{"lui neg",   32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0};
        vecs[4]  = '{"jal +8",    32'h008000EF, 64'h0000_0000_0000_0008, 3'd4, 1'b0};
        vecs[5]  = '{"jal -4",    32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 1'b0};
        vecs[6]  = '{"auipc pos", 32'h12345017, 64'h0000_0000_1234_5000, 3'd3, 1'b0};
        vecs[7]  = '{"ld +8",     32'h00813083, 64'h0000_0000_0000_0008, 3'd0, 1'b0};
        vecs[8]  = '{"addiw max", 32'h7FF0009B, 64'h0000_0000_0000_07FF, 3'd0, 1'b0};
        vecs[9]  = '{"jalr min",  32'h800080E7, 64'hFFFF_FFFF_FFFF_F800, 3'd0, 1'b0};
        vecs[10] = '{"sw +8",     32'h00112423, 64'h0000_0000_0000_0008, 3'd1, 1'b0};
        vecs[11] = '{"beq +8",    32'h00208463, 64'h0000_0000_0000_0008, 3'd2, 1'b0};
        vecs[12] = '{"r-type",    32'h00000033, 64'h0000_0000_0000_0000, 3'd7, 1'b1};

        // Reset state
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rdy in reset 64", 64'(b64.in_ready), 64'd0);
        check("rdy in reset 32", 64'(b32.in_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("post reset");
        check_cnt("post reset");

        // Table: one accept per vector, popped on the edge that accepts the next one
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].instr, 1'b1);
            @(posedge clk);
            #1 drive(1'b0, 32'h0, 1'b1);
            if (vecs[i].ill) begin
                exp64 = (exp64 < 3) ? exp64 + 1 : 3;
                exp32++;
            end
            @(negedge clk);
            check_head(vecs[i].name, vecs[i].imm, vecs[i].fmt, vecs[i].ill);
            check_cnt(vecs[i].name);
        end
        @(posedge clk);
        @(negedge clk);
        check_idle("drained");

        // Backpressure: three offers with out_ready low, only two accepted
        drive(1'b1, 32'h00100093, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 32'h00200093, 1'b0);
        @(negedge clk);
        check("bp rdy after 1", 64'(b64.in_ready), 64'd1);
        check_head("bp head A", 64'd1, 3'd0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 32'h00300093, 1'b0);
        @(negedge clk);
        check("bp rdy full 64", 64'(b64.in_ready), 64'd0);
        check("bp rdy full 32", 64'(b32.in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp still full", 64'(b64.in_ready), 64'd0);
        check_head("bp head stable", 64'd1, 3'd0, 1'b0);
        drive(1'b1, 32'h00300093, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("bp rdy after pop", 64'(b64.in_ready), 64'd1);
        check_head("bp head B", 64'd2, 3'd0, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_head("bp head C", 64'd3, 3'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_idle("bp drained");

        // Illegal-opcode saturation from a fresh reset
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp64 = 0;
        exp32 = 0;
        @(negedge clk);
        check_cnt("sat start");
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h0000007F, 1'b1);
            @(posedge clk);
            #1 drive(1'b0, 32'h0, 1'b1);
            exp64 = (exp64 < 3) ? exp64 + 1 : 3;
            exp32++;
            @(negedge clk);
            check_head("sat", 64'd0, 3'd7, 1'b1);
            check_cnt("sat");
        end
        @(posedge clk);
        @(negedge clk);
        check_idle("sat drained");

        // Reset while FULL discards both entries and the count
        drive(1'b1, 32'h0000007F, 1'b0);
        repeat (2) @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b0);
        exp32 += 2;
        @(negedge clk);
        check("full before reset", 64'(b64.in_ready), 64'd0);
        check_cnt("full before reset");
        reset = 1'b1;
        #1;
        check("rdy during reset", 64'(b32.in_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp64 = 0;
        exp32 = 0;
        @(negedge clk);
        check_idle("after full reset");
        check_cnt("after full reset");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
